index_mul_arbiter: RTL

- Shares one pipelined 16x16 index multiplier (fixed latency, clock-enable controlled) between NUM_REQ requesters.
- Round-robin arbitration issues at most one multiply per cycle.
- A tag pipeline matched to the multiplier latency routes each product back to the requester that issued it.
- Drives the multiplier clock-enable so the pipeline never freezes while operations are in flight, and drops it when idle.

---
 rtl/index_mul_arbiter_pkg.sv | 11 +
 rtl/index_mul_arbiter_if.sv | 15 +
 rtl/index_mul_arbiter_rr_arbiter.sv | 28 ++
 rtl/index_mul_arbiter.sv | 76 +++++++
 4 files changed

// File: rtl/index_mul_arbiter_pkg.sv
// index_mul_arbiter_pkg: shared widths, defaults and the tag carried alongside the multiplier pipeline
package index_mul_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MUL_LATENCY = 4;
  localparam int DEF_ID_W = $clog2(DEF_NUM_REQ);
  localparam int OP_W = 16;
  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/index_mul_arbiter_if.sv
// index_mul_arbiter_if: requester-side request/response bundle of the shared multiplier
interface index_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_p;
  modport slave (input req_valid, req_a, req_b, output req_ready, resp_valid, resp_id, resp_p);
  modport master (output req_valid, req_a, req_b, input req_ready, resp_valid, resp_id, resp_p);
endinterface

// File: rtl/index_mul_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from the slot after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);
  logic [ID_W-1:0] j;
  // first requester found at ptr+1, ptr+2, ... (mod N) wins
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = ID_W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/index_mul_arbiter.sv
// index_mul_arbiter: shares one pipelined multiplier among requesters, routing products back via a tag pipe
module index_mul_arbiter
  import index_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int ID_W = DEF_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  index_mul_arbiter_if.slave   bus,
  output logic                 mul_ce,
  output logic [OP_W-1:0]      mul_a,
  output logic [OP_W-1:0]      mul_b,
  input  logic [OP_W-1:0]      mul_p,
  output logic                 busy,
  output logic [31:0]          issue_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic            hs, inflight;
  logic [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]     cnt_q, cnt_d;
  tag_t            tag_q [MUL_LATENCY];
  tag_t            tag_d [MUL_LATENCY];
  tag_t            last;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(bus.req_valid), .ptr(ptr_q), .gnt(gnt), .gnt_idx(gnt_idx), .any(hs)
  );

  // grant, operand mux, tag shift and response decode; tags advance only with the multiplier
  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k < MUL_LATENCY; k++) inflight = inflight | tag_q[k].valid;
    mul_ce = (|bus.req_valid) | inflight;
    bus.req_ready = gnt;
    op_a_d = hs ? bus.req_a[gnt_idx*OP_W +: OP_W] : op_a_q;
    op_b_d = hs ? bus.req_b[gnt_idx*OP_W +: OP_W] : op_b_q;
    mul_a = op_a_d;
    mul_b = op_b_d;
    ptr_d = hs ? gnt_idx : ptr_q;
    cnt_d = cnt_q + 32'(hs);
    tag_d[0].valid = mul_ce ? hs : tag_q[0].valid;
    tag_d[0].id = mul_ce ? DEF_ID_W'(gnt_idx) : tag_q[0].id;
    for (int k = 1; k < MUL_LATENCY; k++) tag_d[k] = mul_ce ? tag_q[k-1] : tag_q[k];
    state_d = mul_ce ? RUN : IDLE;
    last = tag_q[MUL_LATENCY-1];
    bus.resp_valid = last.valid ? NUM_REQ'(1) << last.id : '0;
    bus.resp_id = last.valid ? ID_W'(last.id) : '0;
    bus.resp_p = mul_p;
    busy = state_q == RUN;
    issue_cnt = cnt_q;
  end

  // state, pointer, tag pipe, operand hold and issue counter; reset drops in-flight tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(NUM_REQ - 1);
      op_a_q <= '0;
      op_b_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < MUL_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end
endmodule
